// File: rtl/multiplier_top.sv
// Sequential unsigned shift-and-add multiplier.
// A and B arrive on one shared bus, B_DELAY edges apart; the product is held with done high.
module multiplier_top #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned B_DELAY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned GAP_W = (B_DELAY > 1) ? $clog2(B_DELAY) : 1;
    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(B_DELAY - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_LOAD_B,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   a_q, a_n;
    logic [WIDTH-1:0]   b_q, b_n;
    logic [PW-1:0]      acc_q, acc_n;
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic [BIT_W-1:0]   bit_q, bit_n;
    logic               done_n;
    logic [PW-1:0]      result_n;

    logic [PW-1:0]      addend;
    logic [PW-1:0]      sum;

    // One partial product per cycle, multiplier bit selected by bit_q
    always_comb begin
        addend = b_q[bit_q] ? (PW'(a_q) << bit_q) : '0;
        sum    = acc_q + addend;
    end

    // Next-state and datapath update
    always_comb begin
        state_n  = state_q;
        a_n      = a_q;
        b_n      = b_q;
        acc_n    = acc_q;
        gap_n    = gap_q;
        bit_n    = bit_q;
        done_n   = done;
        result_n = result;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_n     = data_in;
                    gap_n   = GAP_W'(1);
                    done_n  = 1'b0;
                    state_n = (B_DELAY > 1) ? S_GAP : S_LOAD_B;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_n = S_LOAD_B;
                end else begin
                    gap_n = gap_q + GAP_W'(1);
                end
            end
            S_LOAD_B: begin
                b_n     = data_in;
                acc_n   = '0;
                bit_n   = '0;
                state_n = S_CALC;
            end
            S_CALC: begin
                acc_n = sum;
                // Fixed WIDTH-cycle latency regardless of operand values
                if (bit_q == BIT_LAST) begin
                    result_n = sum;
                    done_n   = 1'b1;
                    state_n  = S_DONE;
                end else begin
                    bit_n = bit_q + BIT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            acc_q   <= acc_n;
            gap_q   <= gap_n;
            bit_q   <= bit_n;
            done    <= done_n;
            result  <= result_n;
        end
    end

endmodule

// File: tb/tb_multiplier_top.sv
// Self-checking bench for multiplier_top: vector table plus hand-written corner sequences,
// with expected products queued at the B-capture edge and compared when done rises.
module tb_multiplier_top;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned B_DELAY = 3;
    localparam int unsigned PW      = 2 * WIDTH;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             done;
    logic [PW-1:0]    result;

    multiplier_top #(.WIDTH(WIDTH), .B_DELAY(B_DELAY)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [PW-1:0]    exp;
    } vec_t;

    vec_t          vecs [7];
    logic [PW-1:0] sb [$];
    logic [PW-1:0] last_product;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Full transaction: start+A, B after B_DELAY edges, wait for done, compare scoreboard head
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [PW-1:0] exp, input bit inject);
        int            lat;
        int            hold_bad;
        logic [PW-1:0] exp_q;
        lat      = 0;
        hold_bad = 0;
        @(negedge clk);
        start   = 1'b1;
        data_in = a;
        @(posedge clk);
        #1;
        check({tag, " done_drop"}, 32'(done), 32'd0);
        if (result !== last_product) hold_bad++;
        for (int k = 1; k < int'(B_DELAY); k++) begin
            @(negedge clk);
            start   = 1'b0;
            data_in = WIDTH'($urandom);
            @(posedge clk);
            #1;
            if (result !== last_product) hold_bad++;
        end
        @(negedge clk);
        start   = 1'b0;
        data_in = b;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4 * int'(WIDTH); i++) begin
            @(negedge clk);
            start   = inject && (i == 3);
            data_in = WIDTH'($urandom);
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (result !== last_product) hold_bad++;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(WIDTH));
        check({tag, " result_hold"}, 32'(hold_bad), 32'd0);
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            exp_q = sb.pop_front();
            check({tag, " result"}, 32'(result), 32'(exp_q));
            last_product = exp_q;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{a: 8'd255, b: 8'd255, exp: 16'd65025};
        vecs[1] = '{a: 8'd0,   b: 8'd200, exp: 16'd0};
        vecs[2] = '{a: 8'd200, b: 8'd0,   exp: 16'd0};
        vecs[3] = '{a: 8'd1,   b: 8'd1,   exp: 16'd1};
        vecs[4] = '{a: 8'd128, b: 8'd2,   exp: 16'd256};
        vecs[5] = '{a: 8'd170, b: 8'd85,  exp: 16'd14450};
        vecs[6] = '{a: 8'd13,  b: 8'd11,  exp: 16'd143};

        rst          = 1'b1;
        start        = 1'b0;
        data_in      = '0;
        last_product = '0;

        // Reset, then idle with start low
        repeat (2) @(posedge clk);
        #1;
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            data_in = WIDTH'($urandom);
        end
        #1;
        check("idle done", 32'(done), 32'd0);
        check("idle result", 32'(result), 32'd0);

        // Basic product, then confirm it is held
        run_op("3x4", 8'd3, 8'd4, 16'd12, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("3x4 done_held", 32'(done), 32'd1);
        check("3x4 result_held", 32'(result), 32'd12);

        // Restart from DONE: old result must persist until the new one lands
        run_op("5x6", 8'd5, 8'd6, 16'd30, 1'b0);

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
        end

        // start pulse during CALC is ignored
        run_op("7x9 start_in_calc", 8'd7, 8'd9, 16'd63, 1'b1);

        // Reset in the middle of CALC of 15*15
        @(negedge clk);
        start   = 1'b1;
        data_in = 8'd15;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        data_in = WIDTH'($urandom);
        repeat (B_DELAY - 1) @(posedge clk);
        @(negedge clk);
        data_in = 8'd15;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (WIDTH + 2) @(posedge clk);
        #1;
        check("midreset no_leak_done", 32'(done), 32'd0);
        check("midreset no_leak_result", 32'(result), 32'd0);
        last_product = '0;

        run_op("2x3 after_reset", 8'd2, 8'd3, 16'd6, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
